// File: rtl/ws2812_rx.sv
// ws2812_rx -- WS2812 NRZ serial line receiver.
//
// Decodes the single-wire WS2812 protocol by timing high pulses: a pulse longer
// than BIT_THRESH clocks is a 1, otherwise a 0. Every 24 bits form one GRB word,
// MSB first. A low period of RESET_CNT clocks after activity latches the frame.
//
// Parameters:
//   BIT_THRESH  high-time count above which a pulse decodes as 1
//   MIN_HIGH    high times shorter than this are glitches
//   HIGH_MAX    high-time count at which the line is declared stuck high
//   RESET_CNT   low-time count that latches a frame
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   din        in   asynchronous WS2812 serial line
//   grb_out    out  last decoded word {G,R,B}
//   grb_valid  out  one-cycle pulse when grb_out updates
//   frame_end  out  one-cycle pulse when a frame is latched after activity
//   busy       out  high from the first accepted bit until frame_end
//   err        out  one-cycle pulse on glitch, stuck-high or partial word
//   dout       out  cascade output (chain-node mode only, else 0)
//
// Build option: define WS2812_RX_FWD_EN for chain-node mode. Only the first word
// of each frame is decoded; the rest of the frame is forwarded on dout as the
// registered synchronized din until frame_end. Undefined: sniffer mode, every
// word is decoded and dout is tied low.

module ws2812_rx #(
    parameter int BIT_THRESH = 29,
    parameter int MIN_HIGH   = 8,
    parameter int HIGH_MAX   = 156,
    parameter int RESET_CNT  = 18200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [23:0] grb_out,
    output logic        grb_valid,
    output logic        frame_end,
    output logic        busy,
    output logic        err,
    output logic        dout
);

    localparam logic [14:0] THR_C  = 15'(BIT_THRESH);
    localparam logic [14:0] MIN_C  = 15'(MIN_HIGH);
    localparam logic [14:0] HMAX_C = 15'(HIGH_MAX);
    localparam logic [14:0] RST_C  = 15'(RESET_CNT);

`ifdef WS2812_RX_FWD_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    typedef enum logic {LOW, HIGH} state_t;

    state_t      state, state_nx;
    logic        s1, s2, s3;
    logic        rise, fall;
    logic [14:0] cnt;
    logic [4:0]  idx, idx_nx;
    logic [23:0] shreg, shreg_nx;
    logic        stuck, stuck_nx;   // stuck-high reported; ignore the falling edge that ends it
    logic        fwd, fwd_nx;       // first word taken, rest of frame belongs downstream
    logic [23:0] grb_out_nx;
    logic        grb_valid_nx, frame_end_nx, busy_nx, err_nx;

    // Synchronizer plus one delay flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // Level timer: clears on every edge, saturates at RESET_CNT so an idle line
    // sits at the latch value without wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (rise || fall)
            cnt <= '0;
        else if (cnt != RST_C)
            cnt <= cnt + 15'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOW;
            idx       <= '0;
            shreg     <= '0;
            stuck     <= 1'b0;
            fwd       <= 1'b0;
            grb_out   <= '0;
            grb_valid <= 1'b0;
            frame_end <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            shreg     <= shreg_nx;
            stuck     <= stuck_nx;
            fwd       <= fwd_nx;
            grb_out   <= grb_out_nx;
            grb_valid <= grb_valid_nx;
            frame_end <= frame_end_nx;
            busy      <= busy_nx;
            err       <= err_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        shreg_nx     = shreg;
        stuck_nx     = stuck;
        fwd_nx       = fwd;
        grb_out_nx   = grb_out;
        grb_valid_nx = 1'b0;
        frame_end_nx = 1'b0;
        busy_nx      = busy;
        err_nx       = 1'b0;

        case (state)
            LOW: begin
                if (rise) begin
                    state_nx = HIGH;
                    stuck_nx = 1'b0;
                end else if (cnt == RST_C && busy) begin
                    // Frame latch; a word left half-built is an error.
                    frame_end_nx = 1'b1;
                    busy_nx      = 1'b0;
                    fwd_nx       = 1'b0;
                    err_nx       = (idx != 5'd0);
                    idx_nx       = '0;
                    shreg_nx     = '0;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_nx = LOW;
                    stuck_nx = 1'b0;
                    if (!stuck && !fwd) begin
                        if (cnt < MIN_C) begin
                            // Glitch: restart word assembly from scratch.
                            err_nx   = 1'b1;
                            idx_nx   = '0;
                            shreg_nx = '0;
                        end else begin
                            shreg_nx = {shreg[22:0], (cnt > THR_C)};
                            busy_nx  = 1'b1;
                            if (idx == 5'd23) begin
                                grb_out_nx   = shreg_nx;
                                grb_valid_nx = 1'b1;
                                idx_nx       = '0;
                                fwd_nx       = FWD_EN;
                            end else begin
                                idx_nx = idx + 5'd1;
                            end
                        end
                    end
                end else if (cnt == HMAX_C && !stuck) begin
                    // Line stuck high: drop the partial word, wait for release.
                    stuck_nx = 1'b1;
                    err_nx   = 1'b1;
                    idx_nx   = '0;
                    shreg_nx = '0;
                end
            end
            default: state_nx = LOW;
        endcase
    end

`ifdef WS2812_RX_FWD_EN
    // Forward the synchronized line while the node is in pass-through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dout <= 1'b0;
        else
            dout <= fwd_nx & s2;
    end
`else
    assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
module tb_ws2812_rx;

    localparam int RC  = 1000;   // shortened latch time keeps the run brief
    localparam int T0H = 19;
    localparam int T1H = 39;
    localparam int PER = 78;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic [23:0] grb_out;
    logic        grb_valid, frame_end, busy, err, dout;

    int n_chk = 0;
    int n_fail = 0;
    int valid_cnt = 0, fe_cnt = 0, err_cnt = 0, coinc_cnt = 0, dout_hi = 0;
    logic [23:0] exp_q[$];

    ws2812_rx #(.RESET_CNT(RC)) dut (
        .clk(clk), .rst(rst), .din(din), .grb_out(grb_out), .grb_valid(grb_valid),
        .frame_end(frame_end), .busy(busy), .err(err), .dout(dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard and event counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (grb_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) chk("sb_unexpected", 32'(exp_q.size()), 1);
                else chk("sb_word", {8'h0, grb_out}, {8'h0, exp_q.pop_front()});
            end
            if (frame_end) fe_cnt++;
            if (err) err_cnt++;
            if (err && frame_end) coinc_cnt++;
            if (dout) dout_hi++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        din = 1'b1;
        cyc(b ? T1H : T0H);
        din = 1'b0;
        cyc(PER - (b ? T1H : T0H));
    endtask

    task automatic send_bits(input logic [23:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[23-i]);
    endtask

    task automatic idle();
        din = 1'b0;
        cyc(RC + 20);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grb"}, {8'h0, grb_out}, 0);
        chk({tag, "_flags"}, {27'h0, grb_valid, frame_end, busy, err, dout}, 0);
    endtask

    int v0, f0, e0, c0, d0, err_at;

    initial begin
        cyc(3);
        chk_zero("reset");
        rst = 1'b0;
        cyc(2);

        // Single word with latency check on the last bit.
        v0 = valid_cnt; f0 = fe_cnt; e0 = err_cnt;
        exp_q.push_back(24'hA53C0F);
        send_bits(24'hA53C0F, 23);
        chk("busy_mid", {31'h0, busy}, 1);
        din = 1'b1;
        cyc(T1H);
        din = 1'b0;
        cyc(1); chk("lat_e1", {31'h0, grb_valid}, 0);
        cyc(1); chk("lat_e2", {31'h0, grb_valid}, 0);
        cyc(1); chk("lat_e3", {31'h0, grb_valid}, 1);
        cyc(PER - T1H - 3);
        idle();
        chk("w1_out", {8'h0, grb_out}, 32'hA53C0F);
        chk("w1_valid", valid_cnt - v0, 1);
        chk("w1_fe", fe_cnt - f0, 1);
        chk("w1_err", err_cnt - e0, 0);
        chk("w1_busy", {31'h0, busy}, 0);

        // Two words in one frame.
        v0 = valid_cnt; f0 = fe_cnt; e0 = err_cnt; d0 = dout_hi;
        exp_q.push_back(24'h112233);
        send_bits(24'h112233, 24);
        chk("w2_dout_word1", dout_hi - d0, 0);
`ifndef WS2812_RX_FWD_EN
        exp_q.push_back(24'h445566);
`endif
        d0 = dout_hi;
        send_bits(24'h445566, 24);
`ifdef WS2812_RX_FWD_EN
        // 10 ones and 14 zeros forwarded
        chk("w2_dout_word2", ((dout_hi - d0) >= 632 && (dout_hi - d0) <= 680), 1);
        chk("w2_valid", valid_cnt - v0, 1);
`else
        chk("w2_valid", valid_cnt - v0, 2);
`endif
        idle();
        chk("w2_fe", fe_cnt - f0, 1);
        chk("w2_err", err_cnt - e0, 0);

        // Glitch after 5 bits, then a full word.
        v0 = valid_cnt; f0 = fe_cnt; e0 = err_cnt;
        send_bits(24'hFFFFFF, 5);
        din = 1'b1; cyc(4); din = 1'b0; cyc(PER - 4);
        chk("gl_err", err_cnt - e0, 1);
        exp_q.push_back(24'h00FF00);
        send_bits(24'h00FF00, 24);
        idle();
        chk("gl_out", {8'h0, grb_out}, 32'h00FF00);
        chk("gl_err_total", err_cnt - e0, 1);
        chk("gl_fe", fe_cnt - f0, 1);

        // Reset mid-word.
        send_bits(24'hFFC000, 10);
        rst = 1'b1;
        cyc(2);
        chk_zero("midrst");
        rst = 1'b0;
        cyc(2);
        v0 = valid_cnt; f0 = fe_cnt; e0 = err_cnt;
        exp_q.push_back(24'h123456);
        send_bits(24'h123456, 24);
        idle();
        chk("rst_out", {8'h0, grb_out}, 32'h123456);
        chk("rst_valid", valid_cnt - v0, 1);
        chk("rst_fe", fe_cnt - f0, 1);

        // Stuck high from idle.
        v0 = valid_cnt; f0 = fe_cnt; e0 = err_cnt;
        err_at = -1;
        din = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            cyc(1);
            if (err && err_at < 0) err_at = i;
        end
        din = 1'b0;
        chk("stuck_time", (err_at >= 155 && err_at <= 162), 1);
        idle();
        chk("stuck_err", err_cnt - e0, 1);
        chk("stuck_valid", valid_cnt - v0, 0);
        chk("stuck_fe", fe_cnt - f0, 0);

        // Partial word at frame end.
        e0 = err_cnt; f0 = fe_cnt; c0 = coinc_cnt;
        send_bits(24'hABCDEF, 10);
        idle();
        chk("part_err", err_cnt - e0, 1);
        chk("part_fe", fe_cnt - f0, 1);
        chk("part_coinc", coinc_cnt - c0, 1);
        chk("part_hold", {8'h0, grb_out}, 32'h123456);
        chk("part_valid", valid_cnt - v0, 0);

        chk("sb_drained", 32'(exp_q.size()), 0);
`ifndef WS2812_RX_FWD_EN
        chk("dout_tied", dout_hi, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
